// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ack bus between the fetch stage (master) and memory (slave).
interface fetch_stage_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: PC, imem request FSM (FETCH/DISCARD/HELD) and IF/ID register; IF/ID loads one edge after ack.
// Optional FETCH_PERF_EN adds fetch_count/stall_count; stall_F holds PC and IF/ID, PCSrc_D redirect wins over stall.
module fetch_stage #(
  parameter logic [63:0] PC_RESET = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_F,
  input  logic        flush_D,
  input  logic        PCSrc_D,
  input  logic [63:0] branch_target,
  fetch_stage_if.master imem,
  output logic [31:0] instr_D,
  output logic [63:0] pc_D,
  output logic        valid_D,
  output logic [10:0] opcode_D
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DISCARD = 2'd1,
    S_HELD    = 2'd2
  } fs_state_t;

  fs_state_t   state;
  logic [63:0] pc;
  logic [31:0] hold_buf;
  logic        req_q;
  logic [63:0] redirect_pc;
  logic        load;
  logic [31:0] load_instr;

  assign redirect_pc = {branch_target[63:2], 2'b00};

  // A redirect drops whatever would have been loaded this cycle.
  always_comb begin
    load       = 1'b0;
    load_instr = imem.imem_rdata;
    if (!PCSrc_D) begin
      if (state == S_FETCH && imem.imem_ack && !stall_F) begin
        load = 1'b1;
      end else if (state == S_HELD && !stall_F) begin
        load       = 1'b1;
        load_instr = hold_buf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      pc       <= PC_RESET;
      hold_buf <= 32'h0;
      req_q    <= 1'b1;
      instr_D  <= 32'h0;
      pc_D     <= 64'h0;
      valid_D  <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (PCSrc_D) begin
            pc <= redirect_pc;
            if (!imem.imem_ack) begin
              state <= S_DISCARD;
              req_q <= 1'b0;
            end
          end else if (imem.imem_ack) begin
            if (stall_F) begin
              hold_buf <= imem.imem_rdata;
              state    <= S_HELD;
              req_q    <= 1'b0;
            end else begin
              pc <= pc + 64'd4;
            end
          end
        end
        S_HELD: begin
          if (PCSrc_D) begin
            pc    <= redirect_pc;
            state <= S_FETCH;
            req_q <= 1'b1;
          end else if (!stall_F) begin
            pc    <= pc + 64'd4;
            state <= S_FETCH;
            req_q <= 1'b1;
          end
        end
        S_DISCARD: begin
          if (PCSrc_D) begin
            pc <= redirect_pc;
          end
          // The single outstanding ack is consumed even alongside a redirect, else nothing would ever leave DISCARD.
          if (imem.imem_ack) begin
            state <= S_FETCH;
            req_q <= 1'b1;
          end
        end
        default: begin
          state <= S_FETCH;
          req_q <= 1'b1;
        end
      endcase

      if (flush_D) begin
        instr_D <= 32'h0;
        valid_D <= 1'b0;
      end else if (load) begin
        instr_D <= load_instr;
        pc_D    <= pc;
        valid_D <= 1'b1;
      end else if (!stall_F) begin
        valid_D <= 1'b0;
      end
    end
  end

  // Reset gating keeps the bus quiet during reset while still requesting in the first free cycle.
  assign imem.imem_req  = req_q & ~reset;
  assign imem.imem_addr = pc;
  assign opcode_D       = instr_D[31:21];

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= 32'h0;
      stall_count <= 32'h0;
    end else begin
      if (load && !flush_D) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (stall_F) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; imem ack/rdata driven by hand per step.
module tb_fetch_stage;

  localparam int S_FETCH   = 0;
  localparam int S_DISCARD = 1;
  localparam int S_HELD    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_F;
  logic        flush_D;
  logic        PCSrc_D;
  logic [63:0] branch_target;
  logic [31:0] instr_D;
  logic [63:0] pc_D;
  logic        valid_D;
  logic [10:0] opcode_D;
  int          checks   = 0;
  int          failures = 0;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
  logic [31:0] sc_snap;
  logic [31:0] fc_snap;
`endif

  fetch_stage_if imem ();

  fetch_stage #(.PC_RESET(64'h0)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall_F       (stall_F),
    .flush_D       (flush_D),
    .PCSrc_D       (PCSrc_D),
    .branch_target (branch_target),
    .imem          (imem.master),
    .instr_D       (instr_D),
    .pc_D          (pc_D),
    .valid_D       (valid_D),
    .opcode_D      (opcode_D)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count   (fetch_count),
    .stall_count   (stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; stall_F = 1'b0; flush_D = 1'b0; PCSrc_D = 1'b0;
    branch_target = 64'h0; imem.imem_ack = 1'b0; imem.imem_rdata = 32'h0;
    tick();
    tick();
    chk("req_in_reset", 64'(imem.imem_req), 64'd0);
    reset = 1'b0;
    #1;
    chk("req_after_reset", 64'(imem.imem_req), 64'd1);
    chk("addr_after_reset", imem.imem_addr, 64'h0);
    chk("valid_reset", 64'(valid_D), 64'd0);
    chk("instr_reset", 64'(instr_D), 64'd0);
    chk("pcd_reset", pc_D, 64'd0);

    // ack tied high, three fetches
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'hF84003E1;
    tick(); tick(); tick();
    chk("stream_pcd", pc_D, 64'd8);
    chk("stream_valid", 64'(valid_D), 64'd1);
    chk("stream_opcode", 64'(opcode_D), 64'h7C2);
    chk("stream_addr", imem.imem_addr, 64'hC);

    // ack under stall goes to HELD
    imem.imem_rdata = 32'hAAAA0001; stall_F = 1'b1;
    tick();
    chk("held_state", 64'(dut.state), 64'(S_HELD));
    chk("held_req", 64'(imem.imem_req), 64'd0);
    chk("held_instr", 64'(instr_D), 64'hF84003E1);
    chk("held_pcd", pc_D, 64'd8);
    chk("held_addr", imem.imem_addr, 64'hC);
    imem.imem_rdata = 32'hDEADBEEF;
    tick(); tick();
    chk("held_state2", 64'(dut.state), 64'(S_HELD));
    chk("held_instr2", 64'(instr_D), 64'hF84003E1);
    stall_F = 1'b0; imem.imem_ack = 1'b0;
    tick();
    chk("release_instr", 64'(instr_D), 64'hAAAA0001);
    chk("release_pcd", pc_D, 64'hC);
    chk("release_valid", 64'(valid_D), 64'd1);
    chk("release_state", 64'(dut.state), 64'(S_FETCH));
    chk("release_addr", imem.imem_addr, 64'h10);
    tick();
    chk("bubble_valid", 64'(valid_D), 64'd0);
    chk("bubble_addr", imem.imem_addr, 64'h10);

    // redirect while waiting for ack
    PCSrc_D = 1'b1; branch_target = 64'h43;
    tick();
    chk("disc_state", 64'(dut.state), 64'(S_DISCARD));
    chk("disc_req", 64'(imem.imem_req), 64'd0);
    chk("disc_addr", imem.imem_addr, 64'h40);
    PCSrc_D = 1'b0;
    tick();
    chk("disc_state2", 64'(dut.state), 64'(S_DISCARD));
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'h12345678;
    tick();
    chk("late_ack_valid", 64'(valid_D), 64'd0);
    chk("late_ack_instr", 64'(instr_D), 64'hAAAA0001);
    chk("late_ack_req", 64'(imem.imem_req), 64'd1);
    chk("late_ack_addr", imem.imem_addr, 64'h40);
    imem.imem_rdata = 32'h0BADF00D;
    tick();
    chk("target_instr", 64'(instr_D), 64'h0BADF00D);
    chk("target_pcd", pc_D, 64'h40);
    chk("target_addr", imem.imem_addr, 64'h44);

    // redirect coincident with ack drops the word
    imem.imem_rdata = 32'h11111111; PCSrc_D = 1'b1; branch_target = 64'h100;
    tick();
    chk("redir_ack_valid", 64'(valid_D), 64'd0);
    chk("redir_ack_instr", 64'(instr_D), 64'h0BADF00D);
    chk("redir_ack_addr", imem.imem_addr, 64'h100);
    chk("redir_ack_state", 64'(dut.state), 64'(S_FETCH));

    // flush overrides stall hold and new load
    PCSrc_D = 1'b0; imem.imem_rdata = 32'h22222222;
    tick();
    chk("pre_flush_instr", 64'(instr_D), 64'h22222222);
    flush_D = 1'b1; stall_F = 1'b1; imem.imem_ack = 1'b0;
    tick();
    chk("flush_stall_valid", 64'(valid_D), 64'd0);
    chk("flush_stall_instr", 64'(instr_D), 64'd0);
    chk("flush_stall_addr", imem.imem_addr, 64'h104);
    stall_F = 1'b0; imem.imem_ack = 1'b1; imem.imem_rdata = 32'h55555555;
    tick();
    chk("flush_load_valid", 64'(valid_D), 64'd0);
    chk("flush_load_instr", 64'(instr_D), 64'd0);
    chk("flush_load_addr", imem.imem_addr, 64'h108);

    // redirect beats stall in HELD
    flush_D = 1'b0; stall_F = 1'b1; imem.imem_rdata = 32'h33333333;
    tick();
    chk("held2_state", 64'(dut.state), 64'(S_HELD));
    PCSrc_D = 1'b1; branch_target = 64'h203;
    tick();
    chk("held_redir_state", 64'(dut.state), 64'(S_FETCH));
    chk("held_redir_addr", imem.imem_addr, 64'h200);
    chk("held_redir_valid", 64'(valid_D), 64'd0);

    // reset while HELD
    PCSrc_D = 1'b0;
    tick();
    chk("held3_state", 64'(dut.state), 64'(S_HELD));
    reset = 1'b1;
    tick();
    chk("rst_held_state", 64'(dut.state), 64'(S_FETCH));
    chk("rst_held_valid", 64'(valid_D), 64'd0);
    chk("rst_held_req", 64'(imem.imem_req), 64'd0);
    chk("rst_held_addr", imem.imem_addr, 64'h0);
    tick();
    chk("rst_held_req2", 64'(imem.imem_req), 64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_req", 64'(imem.imem_req), 64'd1);
    stall_F = 1'b0; imem.imem_rdata = 32'h44444444;
    tick();
    chk("post_rst_instr", 64'(instr_D), 64'h44444444);
    chk("post_rst_pcd", pc_D, 64'h0);
    chk("post_rst_addr", imem.imem_addr, 64'h4);

`ifdef FETCH_PERF_EN
    imem.imem_ack = 1'b0; stall_F = 1'b1;
    sc_snap = stall_count; fc_snap = fetch_count;
    for (int i = 0; i < 5; i++) tick();
    chk("stall_count_delta", 64'(stall_count - sc_snap), 64'd5);
    chk("fetch_count_hold", 64'(fetch_count), 64'(fc_snap));
    stall_F = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter: PC_RESET, 64'h0, PC value loaded on reset.
REQ-002 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: stall_F  in  1  hold PC and IF/ID register.
REQ-005 SHALL have port: flush_D  in  1  turn IF/ID contents into a bubble.
REQ-006 SHALL have port: PCSrc_D  in  1  branch redirect request from decode.
REQ-007 SHALL have port: branch_target  in  64  redirect PC; bits [1:0] ignored.
REQ-008 SHALL have port: imem_req  out  1  instruction memory request.
REQ-009 SHALL have port: imem_addr  out  64  request address (current PC).
REQ-010 SHALL have port: imem_ack  in  1  memory data valid; may arrive in the same cycle as imem_req or later.
REQ-011 SHALL have port: imem_rdata  in  32  instruction word, valid when imem_ack=1.
REQ-012 SHALL have ports: instr_D  out  32; pc_D  out  64; valid_D  out  1; IF/ID register contents.
REQ-013 SHALL have port: opcode_D  out  11  instr_D[31:21], the decoder opcode field.
REQ-014 SHALL have one clock domain (clk) with synchronous active-high reset (reset).

Function
REQ-015 SHALL implement states FETCH, DISCARD, HELD.
REQ-016 FETCH: imem_req=1 and imem_addr=PC.
REQ-017 DISCARD and HELD: imem_req=0.
REQ-018 FETCH, imem_ack=1, stall_F=0, PCSrc_D=0: on the next edge, IF/ID SHALL load {imem_rdata, PC}, valid_D SHALL become 1, and PC SHALL become PC+4 (64-bit wrap).
REQ-019 FETCH, imem_ack=1, stall_F=1, PCSrc_D=0: the block SHALL capture imem_rdata into a hold buffer, go to HELD, and leave PC and IF/ID unchanged.
REQ-020 HELD, stall_F=0: the block SHALL load the hold buffer and PC into IF/ID, set PC to PC+4, and go to FETCH.
REQ-021 HELD, stall_F=1: the block SHALL stay in HELD.
REQ-022 PCSrc_D=1 in any state SHALL set PC to {branch_target[63:2],2'b00} on the next edge; this redirect SHALL take priority over stall_F for the PC.
REQ-023 On redirect, the instruction accepted or held in that cycle SHALL be dropped and SHALL NOT enter IF/ID.
REQ-024 Redirect in FETCH with imem_ack=0 SHALL go to DISCARD; the first later imem_ack SHALL be dropped, then the state SHALL go to FETCH.
REQ-025 Redirect in HELD SHALL go to FETCH.
REQ-026 Redirect in DISCARD SHALL update PC and stay in DISCARD.
REQ-027 flush_D=1 SHALL set valid_D=0 and instr_D=32'h0 on the next edge, overriding both stall hold and a new load.
REQ-028 flush_D does not affect PC or state.
REQ-029 stall_F=1 with no flush SHALL hold instr_D, pc_D and valid_D.
REQ-030 imem_ack SHALL be ignored whenever imem_req=0, except the single pending ack in DISCARD.
REQ-031 The block SHALL have no combinational path from imem_rdata to any output.

Reset
REQ-032 Reset SHALL set PC=PC_RESET, state=FETCH, instr_D=0, pc_D=0, valid_D=0 and the hold buffer to 0.
REQ-033 imem_req SHALL be 0 in every cycle with reset=1; the first request SHALL be made in the first cycle with reset=0.
REQ-034 Reset during DISCARD or HELD SHALL abandon the outstanding or held instruction; an ack arriving during reset SHALL be ignored.

Configuration
REQ-035 With FETCH_PERF_EN defined, the block SHALL add output fetch_count (32), which increments on each IF/ID load with valid_D=1 resulting.
REQ-036 With FETCH_PERF_EN defined, the block SHALL add output stall_count (32), which increments on each cycle with stall_F=1 and reset=0.
REQ-037 Both counters SHALL wrap 32'hFFFFFFFF -> 0 and reset to 0.
REQ-038 Without FETCH_PERF_EN, the ports and counters SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-039 Reset, PC_RESET=0, imem_ack tied 1, rdata=32'hF84003E1: after 3 edges, pc_D=8, valid_D=1, opcode_D=11'h7C2.
REQ-040 Ack in cycle 2 with stall_F=1 held 3 cycles: state HELD; instr_D unchanged; after stall drops, instr_D=held word and PC advances by 4 once.
REQ-041 Request at PC=0x10, ack delayed 2 cycles, PCSrc_D=1 with target 0x43 in the wait cycle: late ack dropped; next request imem_addr=0x40.
REQ-042 flush_D=1 together with stall_F=1: next cycle valid_D=0, instr_D=0; PC unchanged.
REQ-043 Reset asserted while in HELD: next cycle state FETCH, valid_D=0, imem_req=0 until reset drops.
REQ-044 FETCH_PERF_EN defined, counters preset near 32'hFFFFFFFF: wrap to 0; 5 stall cycles give stall_count=5.
